data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access is IDLE -> ACCESS -> RESP, with registered memory strobes and acks.
module data_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              memwrite,
    output logic              memread,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_r;
    logic              last_grant_r;
    logic              lat_id_r;
    logic              grant_valid_s;
    logic              grant_id_s;
    logic              grant_we_s;
    logic [ADDR_W-1:0] grant_addr_s;
    logic [DATA_W-1:0] grant_wdata_s;

    // Round-robin winner selection and mux of the winner's request fields.
    always_comb begin
        grant_valid_s = req0 | req1;
        grant_id_s    = 1'b0;
        grant_we_s    = 1'b0;
        grant_addr_s  = {ADDR_W{1'b0}};
        grant_wdata_s = {DATA_W{1'b0}};
        if (req0 && req1) begin
            grant_id_s = ~last_grant_r;
        end else if (req1) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        if (grant_id_s) begin
            grant_we_s    = we1;
            grant_addr_s  = addr1;
            grant_wdata_s = wdata1;
        end else begin
            grant_we_s    = we0;
            grant_addr_s  = addr0;
            grant_wdata_s = wdata0;
        end
    end

    // Arbiter FSM; the memory-side outputs double as the latched access fields.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            lat_id_r     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            memwrite     <= 1'b0;
            memread      <= 1'b0;
            address      <= {ADDR_W{1'b0}};
            write_data   <= {DATA_W{1'b0}};
            rdata        <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (grant_valid_s) begin
                        state_r      <= ACCESS;
                        last_grant_r <= grant_id_s;
                        lat_id_r     <= grant_id_s;
                        busy         <= 1'b1;
                        memwrite     <= grant_we_s;
                        memread      <= ~grant_we_s;
                        address      <= grant_addr_s;
                        write_data   <= grant_we_s ? grant_wdata_s : {DATA_W{1'b0}};
                    end else begin
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                        memwrite   <= 1'b0;
                        memread    <= 1'b0;
                        address    <= {ADDR_W{1'b0}};
                        write_data <= {DATA_W{1'b0}};
                    end
                end
                ACCESS: begin
                    // read_data is only valid while memread is asserted this cycle.
                    if (memread) begin
                        rdata <= read_data;
                    end else begin
                        rdata <= rdata;
                    end
                    state_r    <= RESP;
                    busy       <= 1'b1;
                    ack0       <= ~lat_id_r;
                    ack1       <= lat_id_r;
                    memwrite   <= 1'b0;
                    memread    <= 1'b0;
                    address    <= {ADDR_W{1'b0}};
                    write_data <= {DATA_W{1'b0}};
                end
                RESP: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    busy       <= 1'b0;
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    memwrite   <= 1'b0;
                    memread    <= 1'b0;
                    address    <= {ADDR_W{1'b0}};
                    write_data <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus a randomized
// run scored against a cycle-timeline reference model and a behavioural memory.
module tb_data_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int VW = 5 + AW + DW + DW;
    localparam int NR = 400;
    localparam logic [VW-1:0] ALL_MASK = {VW{1'b1}};
    localparam logic [VW-1:0] RD_MASK  = {{(5 + AW){1'b1}}, {DW{1'b0}}, {DW{1'b1}}};
    localparam logic [DW-1:0] PAT_A    = 64'hAAAA_AAAA_AAAA_AAAA;

    logic          clock;
    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1, address;
    logic [DW-1:0] wdata0, wdata1, rdata, write_data, read_data;
    logic          ack0, ack1, busy, memwrite, memread;
    logic [VW-1:0] obs_v;
    logic [DW-1:0] env_mem [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .memwrite(memwrite), .memread(memread), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    assign obs_v = {busy, memread, memwrite, ack0, ack1, address, write_data, rdata};
    assign read_data = env_mem[address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 1024; i++) env_mem[i] = 64'd0;
    end

    always @(posedge clock) begin
        if (memwrite) env_mem[address] <= write_data;
    end

    task automatic clear_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 10'd0; addr1 = 10'd0; wdata0 = 64'd0; wdata1 = 64'd0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #1;
        n_checks++;
        if (obs_v !== {VW{1'b0}}) begin
            n_fail++; $display("FAIL reset_async: got %h expected 0", obs_v);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (obs_v !== {VW{1'b0}}) begin
            n_fail++; $display("FAIL reset_idle: got %h expected 0", obs_v);
        end
    endtask

    task automatic test_single_write();
        logic [VW-1:0] e;
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd50; wdata0 = PAT_A;
        @(negedge clock);
        e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd50, PAT_A, 64'd0};
        n_checks++;
        if (obs_v !== e) begin n_fail++; $display("FAIL write_access: got %h expected %h", obs_v, e); end
        @(negedge clock);
        e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 64'd0, 64'd0};
        n_checks++;
        if (obs_v !== e) begin n_fail++; $display("FAIL write_ack: got %h expected %h", obs_v, e); end
        req0 = 1'b0;
        @(negedge clock);
        n_checks++;
        if (obs_v !== {VW{1'b0}}) begin n_fail++; $display("FAIL write_idle: got %h expected 0", obs_v); end
    endtask

    task automatic test_read_back();
        logic [VW-1:0] e;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd50;
        @(negedge clock);
        e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd50, 64'd0, 64'd0};
        n_checks++;
        if ((obs_v & RD_MASK) !== (e & RD_MASK)) begin
            n_fail++; $display("FAIL read_access: got %h expected %h", obs_v, e);
        end
        @(negedge clock);
        e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 64'd0, PAT_A};
        n_checks++;
        if (obs_v !== e) begin n_fail++; $display("FAIL read_ack: got %h expected %h", obs_v, e); end
        req1 = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_contention();
        logic [VW-1:0] e;
        logic          g;
        reset = 1'b0;
        clear_inputs();
        req0 = 1'b1; addr0 = 10'd100; req1 = 1'b1; addr1 = 10'd10;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            g = ((i - 1) / 3) % 2 == 1;
            e = {VW{1'b0}};
            if (i % 3 == 1) e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, g ? 10'd10 : 10'd100, 64'd0, 64'd0};
            if (i % 3 == 2) e = {1'b1, 1'b0, 1'b0, !g, g, 10'd0, 64'd0, 64'd0};
            n_checks++;
            if ((obs_v & RD_MASK) !== (e & RD_MASK)) begin
                n_fail++; $display("FAIL contention_c%0d: got %h expected %h", i, obs_v, e);
            end
        end
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_hold_stability();
        logic [VW-1:0] e;
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd60; wdata0 = 64'h1111_2222_3333_4444;
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'd70; wdata1 = 64'h5555_6666_7777_8888;
        @(negedge clock);
        e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd60, 64'h1111_2222_3333_4444, 64'd0};
        n_checks++;
        if (obs_v !== e) begin n_fail++; $display("FAIL hold_r0_access: got %h expected %h", obs_v, e); end
        addr1 = 10'd71; wdata1 = 64'h9999_AAAA_BBBB_CCCC;
        @(negedge clock);
        e = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 64'd0, 64'd0};
        n_checks++;
        if (obs_v !== e) begin n_fail++; $display("FAIL hold_r0_ack: got %h expected %h", obs_v, e); end
        req0 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd71, 64'h9999_AAAA_BBBB_CCCC, 64'd0};
        n_checks++;
        if (obs_v !== e) begin n_fail++; $display("FAIL hold_r1_access: got %h expected %h", obs_v, e); end
        addr1 = 10'd72; wdata1 = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clock);
        e = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 64'd0, 64'd0};
        n_checks++;
        if (obs_v !== e) begin n_fail++; $display("FAIL hold_r1_ack: got %h expected %h", obs_v, e); end
        req1 = 1'b0;
        n_checks++;
        if (env_mem[71] !== 64'h9999_AAAA_BBBB_CCCC || env_mem[72] !== 64'd0) begin
            n_fail++; $display("FAIL hold_mem: got %h/%h expected 9999aaaabbbbcccc/0", env_mem[71], env_mem[72]);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd200; wdata0 = 64'h0123_4567_89AB_CDEF;
        @(negedge clock);
        n_checks++;
        if (memwrite !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got mw=%b busy=%b expected 1/1", memwrite, busy);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs_v !== {VW{1'b0}}) begin n_fail++; $display("FAIL midrst_async: got %h expected 0", obs_v); end
        req0 = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs_v !== {VW{1'b0}}) begin
                n_fail++; $display("FAIL midrst_after_c%0d: got %h expected 0", i, obs_v);
            end
        end
    endtask

    task automatic test_idle();
        logic [VW-1:0] e;
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd50;
        @(negedge clock);
        @(negedge clock);
        req0 = 1'b0;
        e = {5'b0, 10'd0, 64'd0, PAT_A};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            n_checks++;
            if (obs_v !== e) begin n_fail++; $display("FAIL idle_c%0d: got %h expected %h", i, obs_v, e); end
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] exp_v [0:NR+3];
        logic [VW-1:0] exp_m [0:NR+3];
        logic          rd_upd [0:NR+3];
        logic [DW-1:0] rd_val [0:NR+3];
        logic [DW-1:0] model_mem [int];
        logic [DW-1:0] cur_rd;
        logic          on0, on1, w0, w1, win, wwe;
        logic [AW-1:0] a0, a1, wa;
        logic [DW-1:0] d0, d1, wd, rv;
        int            next_free;
        logic          last;
        for (int i = 0; i <= NR + 3; i++) begin
            exp_v[i] = {VW{1'b0}}; exp_m[i] = ALL_MASK; rd_upd[i] = 1'b0; rd_val[i] = 64'd0;
        end
        on0 = 1'b0; on1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
        a0 = 10'd0; a1 = 10'd0; d0 = 64'd0; d1 = 64'd0;
        do_reset();
        cur_rd = 64'd0; next_free = 0; last = 1'b1;
        for (int c = 0; c < NR; c++) begin
            if (rd_upd[c]) cur_rd = rd_val[c];
            exp_v[c][DW-1:0] = cur_rd;
            n_checks++;
            if ((obs_v & exp_m[c]) !== (exp_v[c] & exp_m[c])) begin
                n_fail++; $display("FAIL random_c%0d: got %h expected %h", c, obs_v, exp_v[c]);
            end
            // Requesters: hold until ack, then drop or re-request with fresh fields.
            if ((on0 && ack0) || !on0) begin
                on0 = (on0 && ack0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                w0 = $urandom_range(0, 1); a0 = AW'(512 + $urandom_range(0, 7));
                d0 = {$urandom, $urandom};
            end
            if ((on1 && ack1) || !on1) begin
                on1 = (on1 && ack1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                w1 = $urandom_range(0, 1); a1 = AW'(512 + $urandom_range(0, 7));
                d1 = {$urandom, $urandom};
            end
            req0 = on0; we0 = w0; addr0 = a0; wdata0 = d0;
            req1 = on1; we1 = w1; addr1 = a1; wdata1 = d1;
            if (c >= next_free && (on0 || on1)) begin
                win = (on0 && on1) ? !last : on1;
                last = win; next_free = c + 3;
                wwe = win ? w1 : w0; wa = win ? a1 : a0; wd = win ? d1 : d0;
                exp_v[c+1] = {1'b1, !wwe, wwe, 1'b0, 1'b0, wa, wwe ? wd : 64'd0, 64'd0};
                exp_m[c+1] = wwe ? ALL_MASK : RD_MASK;
                exp_v[c+2] = {1'b1, 1'b0, 1'b0, !win, win, 10'd0, 64'd0, 64'd0};
                if (wwe) begin
                    model_mem[int'(wa)] = wd;
                end else begin
                    rv = model_mem.exists(int'(wa)) ? model_mem[int'(wa)] : 64'd0;
                    rd_upd[c+2] = 1'b1; rd_val[c+2] = rv;
                end
            end
            @(negedge clock);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_hold_stability();
        test_reset_mid_access();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
